// File: rtl/ram_wr_ctrl.sv
// ram_wr_ctrl -- write-side initiator for the 32R1W RAM's single write port.
//
// Client write requests are buffered in a small FIFO and drained one per
// cycle onto the registered RAM write port (w_addr_1 / w_din_1 / w_enb_1).
// A fill engine writes a single latched value to every address. The fill
// starts only once all earlier client writes have drained.
//
// Parameters
//   BLOCKSIZE   address MSB index; address width AW = BLOCKSIZE+1
//   DATA_W      write data width
//   FIFO_DEPTH  request FIFO entries (power of 2, >= 2)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   req_valid    client write request valid
//   req_ready    FIFO can accept (= !full)
//   req_addr     client write address
//   req_data     client write data
//   fill_start   one-cycle pulse requesting a full-memory fill
//   fill_value   fill data, latched when fill_start is taken in IDLE
//   w_addr_1     RAM write address (registered)
//   w_din_1      RAM write data (registered)
//   w_enb_1      RAM write enable (registered)
//   busy         fill pending/running, or FIFO non-empty
//   fill_done    one-cycle pulse, high alongside the last fill write
//
// Build option
//   WR_BYPASS_EN  when defined, a request taken in IDLE while the FIFO is
//                 empty goes straight onto the write port (1-cycle latency)
//                 and is not stored in the FIFO.

module ram_wr_ctrl #(
    parameter int BLOCKSIZE  = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BLOCKSIZE:0]  req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic                fill_start,
    input  logic [DATA_W-1:0]   fill_value,
    output logic [BLOCKSIZE:0]  w_addr_1,
    output logic [DATA_W-1:0]   w_din_1,
    output logic                w_enb_1,
    output logic                busy,
    output logic                fill_done
);

    localparam int AW = BLOCKSIZE + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL_WAIT, FILL} state_t;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    wr_req_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [PW:0]    occ_q, occ_d;
    logic           fifo_empty, fifo_full;
    logic           push, pop, bypass;
    wr_req_t        head;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == (PW+1)'(FIFO_DEPTH));
    assign req_ready  = !fifo_full;
    assign head       = mem_q[rptr_q];

    // A full FIFO refuses the push even if it pops on the same edge.
    assign push = req_valid && req_ready && !bypass;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= '{addr: req_addr, data: req_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end

    // ---------------------------------------------------------------
    // Control FSM and write-port registers
    // ---------------------------------------------------------------
    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]  fval_q, fval_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdin_q, wdin_d;
    logic               wenb_q, wenb_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fval_d  = fval_q;
        waddr_d = waddr_q;   // address/data hold when nothing is written
        wdin_d  = wdin_q;
        wenb_d  = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        bypass  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
`ifdef WR_BYPASS_EN
                // FIFO empty implies req_ready, so the request is taken now.
                else if (req_valid) begin
                    bypass = 1'b1;
                end
`endif
                if (fill_start) begin
                    state_d = FILL_WAIT;
                    fval_d  = fill_value;
                end
            end
            FILL_WAIT: begin
                // Earlier client writes must land before the fill overwrites.
                if (!fifo_empty) pop = 1'b1;
                else             state_d = FILL;
            end
            FILL: begin
                waddr_d = cnt_q;
                wdin_d  = fval_q;
                wenb_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;  // wraps to 0 after the last address
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            waddr_d = head.addr;
            wdin_d  = head.data;
            wenb_d  = 1'b1;
        end
        if (bypass) begin
            waddr_d = req_addr;
            wdin_d  = req_data;
            wenb_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fval_q  <= '0;
            waddr_q <= '0;
            wdin_q  <= '0;
            wenb_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fval_q  <= fval_d;
            waddr_q <= waddr_d;
            wdin_q  <= wdin_d;
            wenb_q  <= wenb_d;
            done_q  <= done_d;
        end
    end

    assign w_addr_1  = waddr_q;
    assign w_din_1   = wdin_q;
    assign w_enb_1   = wenb_q;
    assign fill_done = done_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Self-checking bench for ram_wr_ctrl (default parameters: AW=11, DATA_W=32,
// FIFO_DEPTH=4). A table of per-cycle vectors covers single and streamed
// writes; hand-written sequences cover reset, fill, back-pressure and
// fill ordering. A monitor logs every RAM write for the sequence checks.

module tb_ram_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic [31:0] req_data;
    logic        fill_start;
    logic [31:0] fill_value;
    logic [10:0] w_addr_1;
    logic [31:0] w_din_1;
    logic        w_enb_1;
    logic        busy;
    logic        fill_done;

    ram_wr_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .w_addr_1   (w_addr_1),
        .w_din_1    (w_din_1),
        .w_enb_1    (w_enb_1),
        .busy       (busy),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- write monitor ----------------
    typedef struct packed {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  fd_cnt = 0;
    int  fd_at  = -1;
    logic fd_busy = 1'b1;

    always @(negedge clk) begin
        if (w_enb_1) wq.push_back({w_addr_1, w_din_1});
        if (fill_done) begin
            fd_cnt++;
            fd_at   = wq.size();
            fd_busy = busy;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [10:0] a;
        logic [31:0] d;
        logic        e_en;
        logic [10:0] e_a;
        logic [31:0] e_d;
        logic        e_busy;
    } vec_t;

    vec_t tv[9];

    // ---------------- helpers ----------------
    task automatic start_fill(input logic [31:0] val);
        @(negedge clk); #1;
        wq.delete();
        fd_cnt = 0;
        fd_at  = -1;
        fill_start = 1'b1;
        fill_value = val;
        @(negedge clk);
        fill_start = 1'b0;
        fill_value = ~val;   // must not be re-sampled
    endtask

    task automatic wait_fd(input int maxc);
        int n = 0;
        while (fd_cnt == 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("fill_done_seen", (fd_cnt != 0), 1);
    endtask

    task automatic wait_writes(input int cnt, input int maxc);
        int n = 0;
        while (wq.size() < cnt && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("writes_seen", (wq.size() >= cnt), 1);
    endtask

    task automatic check_fill(input string name, input int base, input logic [31:0] val);
        int bad = 0;
        if (wq.size() < base + 2048) begin
            bad = 2048;
        end else begin
            for (int k = 0; k < 2048; k++)
                if (wq[base+k].a !== 11'(k) || wq[base+k].d !== val) bad++;
        end
        chk(name, bad, 0);
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_enb"},   w_enb_1,   0);
        chk({tag, "_addr"},  w_addr_1,  0);
        chk({tag, "_din"},   w_din_1,   0);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  fill_done, 0);
    endtask

    initial begin
        int n;
        int bad;
        logic ready_ok;

        tv[0] = '{1'b1, 11'h005, 32'hDEADBEEF, 1'b0, 11'h000, 32'h00000000, 1'b0};
        tv[1] = '{1'b0, 11'h000, 32'h00000000, 1'b0, 11'h000, 32'h00000000, 1'b1};
        tv[2] = '{1'b1, 11'h7FF, 32'h11111111, 1'b1, 11'h005, 32'hDEADBEEF, 1'b0};
        tv[3] = '{1'b1, 11'h000, 32'h22222222, 1'b0, 11'h005, 32'hDEADBEEF, 1'b1};
        tv[4] = '{1'b1, 11'h005, 32'h33333333, 1'b1, 11'h7FF, 32'h11111111, 1'b1};
        tv[5] = '{1'b0, 11'h000, 32'h00000000, 1'b1, 11'h000, 32'h22222222, 1'b1};
        tv[6] = '{1'b0, 11'h000, 32'h00000000, 1'b1, 11'h005, 32'h33333333, 1'b0};
        tv[7] = '{1'b0, 11'h000, 32'h00000000, 1'b0, 11'h005, 32'h33333333, 1'b0};
        tv[8] = tv[7];
`ifdef WR_BYPASS_EN
        // Bypass: every write lands one cycle earlier and never occupies the FIFO.
        for (int r = 0; r < 8; r++) begin
            tv[r].e_en = tv[r+1].e_en;
            tv[r].e_a  = tv[r+1].e_a;
            tv[r].e_d  = tv[r+1].e_d;
        end
        for (int r = 0; r < 9; r++) tv[r].e_busy = 1'b0;
`endif

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        fill_start = 1'b0;
        fill_value = '0;

        // Power-on reset.
        #1 rst = 1'b0;
        #2 check_idle_reset("por");
        @(negedge clk);
        rst = 1'b1;

        // Single write and streamed writes (incl. same address twice).
        for (int r = 0; r < 9; r++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_enb", r),   w_enb_1,   tv[r].e_en);
            chk($sformatf("vec%0d_addr", r),  w_addr_1,  tv[r].e_a);
            chk($sformatf("vec%0d_din", r),   w_din_1,   tv[r].e_d);
            chk($sformatf("vec%0d_busy", r),  busy,      tv[r].e_busy);
            chk($sformatf("vec%0d_ready", r), req_ready, 1);
            req_valid = tv[r].v;
            req_addr  = tv[r].a;
            req_data  = tv[r].d;
        end
        req_valid = 1'b0;

        // Reset mid-traffic.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 11'h0AA; req_data = 32'hAAAA0001;
        @(negedge clk);
        req_addr = 11'h0BB; req_data = 32'hBBBB0002;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_pre_enb", w_enb_1, 1);
        #2 rst = 1'b0;
        #1 check_idle_reset("mid_rst");
        wq.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_writes", wq.size(), 0);

        // Full fill from an empty FIFO.
        start_fill(32'hA5A5A5A5);
        wait_fd(2200);
        repeat (3) @(negedge clk);
        chk("fill_count", wq.size(), 2048);
        check_fill("fill_data", 0, 32'hA5A5A5A5);
        chk("fill_done_once", fd_cnt, 1);
        chk("fill_done_with_last", fd_at, 2048);
        chk("fill_done_busy", fd_busy, 0);
        chk("fill_after_busy", busy, 0);

        // Back-pressure: fill the FIFO while the fill owns the port.
        start_fill(32'h5A5A5A5A);
        wait_writes(1, 10);
        ready_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ready_ok &= req_ready;
            req_valid = 1'b1;
            req_addr  = 11'(12'h100 + i);
            req_data  = 32'hB0000000 + i;
        end
        @(negedge clk);
        chk("bp_ready_first4", ready_ok, 1);
        chk("bp_ready_full", req_ready, 0);
        chk("bp_busy", busy, 1);
        req_addr = 11'h104;
        req_data = 32'hB0000004;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_5th_after_fill", fd_cnt, 1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_count", wq.size(), 2048 + 5);
        check_fill("bp_fill_data", 0, 32'h5A5A5A5A);
        bad = 0;
        if (wq.size() >= 2053) begin
            for (int i = 0; i < 5; i++)
                if (wq[2048+i].a !== 11'(12'h100 + i) || wq[2048+i].d !== 32'hB0000000 + i) bad++;
        end else bad = 5;
        chk("bp_order", bad, 0);

        // Pending writes precede the fill; a second fill_start is ignored.
        @(negedge clk); #1;
        wq.delete();
        fd_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 11'h010; req_data = 32'hC0000000;
        @(negedge clk);
        req_addr = 11'h011; req_data = 32'hC0000001;
        @(negedge clk);
        req_addr = 11'h012; req_data = 32'hC0000002;
        fill_start = 1'b1; fill_value = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0; fill_start = 1'b0; fill_value = 32'h0;
        wait_writes(20, 40);
        @(negedge clk);
        fill_start = 1'b1; fill_value = 32'hFFFFFFFF;
        @(negedge clk);
        fill_start = 1'b0;
        wait_fd(2200);
        repeat (20) @(negedge clk);
        chk("pend_count", wq.size(), 2048 + 3);
        bad = 0;
        if (wq.size() >= 3) begin
            for (int i = 0; i < 3; i++)
                if (wq[i].a !== 11'(8'h10 + i) || wq[i].d !== 32'hC0000000 + i) bad++;
        end else bad = 3;
        chk("pend_first3", bad, 0);
        check_fill("pend_fill_data", 3, 32'h12345678);
        chk("pend_done_once", fd_cnt, 1);

        // Reset mid-fill, then a fresh fill restarts at address 0.
        start_fill(32'h0F0F0F0F);
        wait_writes(257, 400);
        chk("rf_addr_0x100", (wq.size() >= 257) ? wq[256].a : 11'h7FF, 11'h100);
        #2 rst = 1'b0;
        #1 check_idle_reset("rf_rst");
        wq.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rf_no_writes", wq.size(), 0);
        chk("rf_no_done", fd_cnt, 0);
        start_fill(32'h77777777);
        wait_fd(2200);
        repeat (3) @(negedge clk);
        chk("rf2_count", wq.size(), 2048);
        check_fill("rf2_data", 0, 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
